// File: rtl/key_schedule.sv
`default_nettype none
// ============================================================================
// key_schedule : AES-128 on-the-fly key expansion, one round key per advance.
// Revision 1.0
// ============================================================================
module key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         advance,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         last_round,
  output logic         key_ready,
  output logic         done
);

  if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
    $error("key_schedule: only NUM_ROUNDS = 10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // Byte 0 of the S-box sits in the most significant byte of this constant.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   round_key_q, round_key_d;
  logic [3:0]     round_num_q, round_num_d;
  logic           key_ready_q, key_ready_d;
  logic           done_q, done_d;

  logic [31:0]    w_rot_word;
  logic [31:0]    w_sub_word;
  logic [31:0]    w_temp;
  logic [31:0]    w_n0, w_n1, w_n2, w_n3;

  assign w_rot_word = {round_key_q[23:0], round_key_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign w_sub_word[8*g +: 8] = sbox(w_rot_word[8*g +: 8]);
  end

  assign w_temp = w_sub_word ^ {rcon(round_num_q), 24'h0};
  assign w_n0   = round_key_q[127:96] ^ w_temp;
  assign w_n1   = round_key_q[95:64]  ^ w_n0;
  assign w_n2   = round_key_q[63:32]  ^ w_n1;
  assign w_n3   = round_key_q[31:0]   ^ w_n2;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_num_d = round_num_q;
    key_ready_d = key_ready_q;
    done_d      = 1'b0;
    // A fresh key always wins, even over a same-cycle advance.
    if (key_load) begin
      state_d     = ACTIVE;
      round_key_d = key_in;
      round_num_d = 4'd0;
      key_ready_d = 1'b1;
    end else if (advance && state_q == ACTIVE) begin
      if (round_num_q == LAST_ROUND) begin
        state_d     = IDLE;
        key_ready_d = 1'b0;
        done_d      = 1'b1;
      end else begin
        round_key_d = {w_n0, w_n1, w_n2, w_n3};
        round_num_d = round_num_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_num_q <= 4'd0;
      key_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_num_q <= round_num_d;
      key_ready_q <= key_ready_d;
      done_q      <= done_d;
    end
  end

  assign round_key  = round_key_q;
  assign round_num  = round_num_q;
  assign last_round = (state_q == ACTIVE) && (round_num_q == LAST_ROUND);
  assign key_ready  = key_ready_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule.sv
`default_nettype none
// ============================================================================
// tb_key_schedule : randomized self-checking bench for key_schedule.
// Revision 1.0
// ============================================================================
module tb_key_schedule;

  localparam logic [127:0] C_FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] C_FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] C_FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_ZERO_R1  = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         advance = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         last_round;
  logic         key_ready;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the key expansion should currently present.
  logic [127:0] m_key;
  int           m_num;
  bit           m_active;
  bit           m_done;
  logic [7:0]   sbox_m [256];

  key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .key_in     (key_in),
    .advance    (advance),
    .round_key  (round_key),
    .round_num  (round_num),
    .last_round (last_round),
    .key_ready  (key_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] expand_m(input logic [127:0] k, input int r);
    logic [7:0] b [16];
    logic [7:0] n [16];
    logic [7:0] t [4];
    logic [7:0] rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < r; i++) rc = xtime(rc);
    for (int i = 0; i < 16; i++) b[i] = k[127 - 8*i -: 8];
    t[0] = sbox_m[b[13]] ^ rc;
    t[1] = sbox_m[b[14]];
    t[2] = sbox_m[b[15]];
    t[3] = sbox_m[b[12]];
    for (int i = 0; i < 16; i++) n[i] = b[i] ^ ((i < 4) ? t[i] : n[i-4]);
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = n[i];
    return res;
  endfunction

  task automatic model_reset();
    m_key = '0; m_num = 0; m_active = 1'b0; m_done = 1'b0;
  endtask

  task automatic compare_all(input string where);
    check({where, ":round_key"},  round_key,  m_key);
    check({where, ":round_num"},  128'(round_num), 128'(m_num));
    check({where, ":last_round"}, 128'(last_round), 128'(m_active && m_num == 10));
    check({where, ":key_ready"},  128'(key_ready), 128'(m_active));
    check({where, ":done"},       128'(done), 128'(m_done));
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, compare 1ns later.
  task automatic step(input logic ld, input logic [127:0] kin, input logic adv, input string where);
    @(negedge clk);
    key_load = ld; key_in = kin; advance = adv;
    @(posedge clk);
    m_done = 1'b0;
    if (ld) begin
      m_key = kin; m_num = 0; m_active = 1'b1;
    end else if (adv && m_active) begin
      if (m_num == 10) begin
        m_active = 1'b0; m_done = 1'b1;
      end else begin
        m_key = expand_m(m_key, m_num); m_num++;
      end
    end
    #1;
    key_load = 1'b0; advance = 1'b0;
    compare_all(where);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset(input string where);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all({where, ":immediate"});
    @(posedge clk);
    #1 compare_all({where, ":held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    build_sbox();
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all("reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, 1'b1, "idle_adv_after_reset");

    // Back-to-back expansion of the FIPS-197 key.
    step(1'b1, C_FIPS_KEY, 1'b0, "load_fips");
    check("fips_r0_const", round_key, C_FIPS_KEY);
    for (int r = 1; r <= 10; r++) begin
      step(1'b0, '0, 1'b1, "b2b");
      if (r == 1)  check("fips_r1_const", round_key, C_FIPS_R1);
      if (r == 2)  check("fips_r2_const", round_key, C_FIPS_R2);
      if (r == 10) check("fips_r10_const", round_key, C_FIPS_R10);
    end
    step(1'b0, '0, 1'b1, "final_adv");
    check("done_pulse", 128'(done), 128'(1));
    check("done_r10_held", round_key, C_FIPS_R10);
    step(1'b0, '0, 1'b0, "done_drops");
    step(1'b0, '0, 1'b1, "idle_adv");

    // Sparse advances with idle gaps.
    step(1'b1, C_FIPS_KEY, 1'b0, "load_sparse");
    for (int r = 1; r <= 10; r++) begin
      step(1'b0, '0, 1'b1, "sparse_adv");
      repeat (3) step(1'b0, '0, 1'b0, "sparse_gap");
    end
    check("sparse_r10_const", round_key, C_FIPS_R10);

    // key_load wins over a simultaneous advance at round 5.
    step(1'b1, C_FIPS_KEY, 1'b0, "load_abort");
    repeat (5) step(1'b0, '0, 1'b1, "to_round5");
    step(1'b1, '0, 1'b1, "load_vs_adv");
    check("abort_zero_key", round_key, '0);
    step(1'b0, '0, 1'b1, "zero_adv");
    check("zero_r1_const", round_key, C_ZERO_R1);

    // Asynchronous reset at round 7, then advance must be ignored.
    step(1'b1, C_FIPS_KEY, 1'b0, "load_rst");
    repeat (7) step(1'b0, '0, 1'b1, "to_round7");
    async_reset("rst_r7");
    step(1'b0, '0, 1'b1, "post_rst_adv");
    step(1'b1, C_FIPS_KEY, 1'b0, "post_rst_load");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
      else step($urandom_range(0, 15) == 0, k, $urandom_range(0, 2) != 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
